// File: rtl/uart_pkg.sv
// Shared types for the framed UART transmitter: parity mode and serializer state.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_ODD,
        PARITY_EVEN
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO buffering words ahead of the UART serializer.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is refused even when a pop frees a slot on the same edge.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = (r_level == LVL_W'(DEPTH));
    assign empty    = (r_level == '0);
    assign level    = r_level;

endmodule

// File: rtl/uart_tx_framed.sv
// UART transmitter: stream input into a FIFO, serialised LSB-first with configurable framing.
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned DATA_BITS  = 8,
    parameter parity_t     PARITY     = PARITY_NONE,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              axi_valid,
    output logic                              axi_ready,
    input  logic [DATA_BITS-1:0]              axi_data,
    output logic                              uart_tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("uart_tx_framed: CLK_DIV must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_tx_framed: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_framed: STOP_BITS must be 1 or 2");
    end

    tx_state_t            r_state;
    logic                 r_tx;
    logic [CNT_W-1:0]     r_baud;
    logic [BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic [DATA_BITS-1:0] w_fifo_data;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_baud_last;
    logic                 w_stop_done;
    logic                 w_pop;

    assign w_baud_last = (r_baud == BAUD_LAST);
    assign w_stop_done = (r_state == STOP) && w_baud_last && (r_bit == STOP_LAST);
    // Popping on the last stop cycle chains frames with no idle gap.
    assign w_pop       = !w_empty && ((r_state == IDLE) || w_stop_done);

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (axi_valid && axi_ready),
        .push_data (axi_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_data),
        .full      (w_full),
        .empty     (w_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
        end else begin
            if (r_state == IDLE || w_baud_last) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + CNT_W'(1);
            end
            if (w_pop) begin
                r_shift <= w_fifo_data;
                r_par   <= (^w_fifo_data) ^ (PARITY == PARITY_ODD);
            end
            unique case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_baud_last) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_bit   <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_baud_last) begin
                        if (r_bit == DATA_LAST) begin
                            r_bit <= '0;
                            if (PARITY != PARITY_NONE) begin
                                r_tx    <= r_par;
                                r_state <= uart_pkg::PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_bit   <= r_bit + BIT_W'(1);
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (w_baud_last) begin
                        r_tx    <= 1'b1;
                        r_bit   <= '0;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_stop_done) begin
                        r_bit <= '0;
                        if (w_pop) begin
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_baud_last) begin
                        r_bit <= r_bit + BIT_W'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign axi_ready = rst_n && !w_full;
    assign uart_tx   = r_tx;
    assign busy      = !w_empty || (r_state != IDLE);

endmodule

// File: doc/uart_tx_framed.md
# uart_tx_framed

Parametrised UART transmitter with input FIFO, programmable frame format and baud divider. Accepts words on a valid/ready stream, buffers up to FIFO_DEPTH words, serialises each LSB-first as a start bit, data bits, optional parity and 1–2 stop bits on `uart_tx`. It is the TX output stage of the measurement-readout path and has no host-side register interface; all configuration is fixed at elaboration.

## Interface
- CLK_DIV, 868, clock cycles per bit, ≥2.
- DATA_BITS, 8, data bits per frame, 5..9.
- PARITY, PARITY_NONE, frame parity mode: PARITY_NONE, PARITY_ODD or PARITY_EVEN (`uart_pkg::parity_t`).
- STOP_BITS, 1, stop bits per frame, 1 or 2.
- FIFO_DEPTH, 4, input FIFO entries, power of two, ≥2.

- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- axi_valid  in  1  input word valid.
- axi_ready  out  1  FIFO can accept a word; transfer on `axi_valid && axi_ready` at a rising edge.
- axi_data  in  DATA_BITS  word to send, bit 0 transmitted first.
- uart_tx  out  1  serial line, idle high.
- busy  out  1  FIFO non-empty or frame in progress.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  words currently buffered.

## Operation
- Reset (rst_n low at an edge): uart_tx=1, axi_ready=0, busy=0, fifo_level=0, FSM to IDLE, FIFO emptied, counters zeroed. axi_ready is forced 0 while rst_n is low; it is 1 from the first cycle after release.
- axi_ready = !full. A push is refused when full even if a pop occurs the same edge.
- Push and pop on the same edge: level unchanged, data ordering preserved.
- FSM states: IDLE → START → DATA → PARITY → STOP → (START or IDLE).
  - IDLE: uart_tx=1. If FIFO non-empty: pop word into shift register, enter START.
  - START: uart_tx=0 for CLK_DIV cycles.
  - DATA: DATA_BITS bits, LSB first, each CLK_DIV cycles.
  - PARITY: skipped when PARITY_NONE; even mode sends XOR of data bits, odd mode sends its inverse.
  - STOP: uart_tx=1 for STOP_BITS×CLK_DIV cycles. At its last cycle, if FIFO non-empty, pop and go directly to START (no idle gap); else IDLE.
- Baud counter: $clog2(CLK_DIV) bits, counts 0..CLK_DIV-1, wraps; bit advance on terminal count. Bit index counter: $clog2(DATA_BITS+1) bits.
- Illegal parameter values stop elaboration via `$error` in an initial/generate check.
- axi_data is captured at push; later changes on the bus do not affect queued words.

## Timing
- Push accepted at edge N into an empty FIFO with FSM in IDLE: pop at edge N+1; uart_tx low from edge N+1 (registered output).
- Frame length exactly (1 + DATA_BITS + (PARITY!=NONE) + STOP_BITS) × CLK_DIV cycles.
- Back-to-back frames: next start bit begins on the edge immediately after the last stop-bit cycle.
- busy falls on the edge uart_tx completes the final stop bit with FIFO empty.
- fifo_level updates on the edge of the push/pop.
- Reset mid-frame: uart_tx returns to 1 on the reset edge; partial frame discarded.

## Structure
- `uart_pkg`: `parity_t` enum (PARITY_NONE, PARITY_ODD, PARITY_EVEN), `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
- Sub-module `uart_fifo`: synchronous FIFO parameterised by WIDTH and DEPTH, ports push/pop/full/empty/level, same clk/rst_n. Serializer FSM in `uart_tx_framed`.

## Test plan
- CLK_DIV=4, DATA_BITS=8, PARITY_EVEN, STOP_BITS=1, send 0xA5 → line 0,1,0,1,0,0,1,0,1,0,1 each held 4 cycles (44 cycles), start edge N+1 after push.
- Same with PARITY_ODD → parity bit 1; PARITY_NONE, STOP_BITS=2, DATA_BITS=7, send 0x41 → 0,1,0,0,0,0,0,1,1,1 (40 cycles).
- FIFO_DEPTH=4, axi_valid held from idle → exactly 5 words accepted on consecutive edges, axi_ready low from the 6th cycle, fifo_level=4, re-asserts when first frame ends.
- Three queued words 0x00,0xFF,0x55 → three frames with no idle cycle between stop and next start; busy drops after third stop bit, fifo_level reaches 0.
- rst_n pulled low for one edge in mid DATA of 0x3C with two words queued → uart_tx=1, fifo_level=0, busy=0 next cycle; no further frames until new push.
- Push while full with simultaneous pop → push refused (axi_ready=0), level drops to DEPTH-1, sent word sequence unchanged.
